// File: rtl/cpu_bus_pkg.sv
// Shared types for the fetch / load-store bus arbiter.
package cpu_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  localparam logic [3:0] SEL_ALL = 4'b1111;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IF_BUSY  = 3'd1,
    MEM_BUSY = 3'd2,
    IF_DONE  = 3'd3,
    MEM_DONE = 3'd4
  } arb_state_e;

  // Everything the bus needs for one transaction, latched at grant.
  typedef struct packed {
    logic                  we;
    logic [3:0]            sel;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Counts cycles spent waiting for a bus ack; flags the last allowed cycle.
module bus_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int             TW   = $clog2(MAX_WAIT) + 1;
  localparam logic [TW-1:0]  LAST = TW'(MAX_WAIT - 1);

  logic [TW-1:0] count_q;

  // Saturating up-counter: holds at the last value instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear)
      count_q <= '0;
    else if (i_enable && (count_q != LAST))
      count_q <= count_q + 1'b1;
  end

  assign o_expire = (count_q == LAST);

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// Shares one Wishbone-style port between instruction fetch and load/store.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | no transaction; grants MEM first, then IF
// IF_BUSY  | fetch cycle on the bus, waiting for ack or timeout
// MEM_BUSY | load/store cycle on the bus, waiting for ack or timeout
// IF_DONE  | fetch data valid, IF stall released for one cycle
// MEM_DONE | load/store complete, MEM stall released for one cycle
module bus_arbiter_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int N_ADDR   = 32,
  parameter int N_DATA   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_ce,
  input  logic [N_ADDR-1:0] i_if_addr,
  output logic [N_DATA-1:0] o_if_rdata,
  output logic              o_if_stallreq,
  input  logic              i_mem_ce,
  input  logic              i_mem_we,
  input  logic [3:0]        i_mem_sel,
  input  logic [N_ADDR-1:0] i_mem_addr,
  input  logic [N_DATA-1:0] i_mem_wdata,
  output logic [N_DATA-1:0] o_mem_rdata,
  output logic              o_mem_stallreq,
  input  logic              i_flush,
  output logic              o_bus_cyc,
  output logic              o_bus_we,
  output logic [3:0]        o_bus_sel,
  output logic [N_ADDR-1:0] o_bus_addr,
  output logic [N_DATA-1:0] o_bus_wdata,
  input  logic [N_DATA-1:0] i_bus_rdata,
  input  logic              i_bus_ack,
  output logic              o_bus_timeout
);

  arb_state_e        state_q, state_d;
  bus_req_t          req_q;
  logic              cyc_q;
  logic              timeout_q;
  logic              discard_q;
  logic [N_DATA-1:0] if_rdata_q, mem_rdata_q;

  logic busy, expire, end_xfer, timeout_hit, if_discard;
  logic grant_if, grant_mem;

  assign busy        = (state_q == IF_BUSY) || (state_q == MEM_BUSY);
  assign end_xfer    = busy && (i_bus_ack || expire);
  assign timeout_hit = busy && expire && !i_bus_ack;
  // A flush arriving in the completing cycle must also drop the fetch.
  assign if_discard  = discard_q || i_flush;

  bus_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (!busy),
    .i_enable (busy),
    .o_expire (expire)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and grant decode; MEM wins ties because it is the older instruction.
  always_comb begin
    state_d   = state_q;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_mem_ce) begin
          state_d   = MEM_BUSY;
          grant_mem = 1'b1;
        end else if (i_if_ce) begin
          state_d  = IF_BUSY;
          grant_if = 1'b1;
        end
      end
      IF_BUSY:  if (end_xfer) state_d = if_discard ? IDLE : IF_DONE;
      MEM_BUSY: if (end_xfer) state_d = MEM_DONE;
      IF_DONE:  state_d = IDLE;
      MEM_DONE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Bus request registers, cycle flag, timeout pulse and captured read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_q       <= '0;
      cyc_q       <= 1'b0;
      timeout_q   <= 1'b0;
      discard_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      timeout_q <= timeout_hit;

      if (grant_mem) begin
        req_q.we    <= i_mem_we;
        req_q.sel   <= i_mem_sel;
        req_q.addr  <= BUS_ADDR_W'(i_mem_addr);
        req_q.wdata <= BUS_DATA_W'(i_mem_wdata);
        cyc_q       <= 1'b1;
      end else if (grant_if) begin
        req_q.we    <= 1'b0;
        req_q.sel   <= SEL_ALL;
        req_q.addr  <= BUS_ADDR_W'(i_if_addr);
        req_q.wdata <= '0;
        cyc_q       <= 1'b1;
      end else if (end_xfer) begin
        cyc_q <= 1'b0;
      end

      if ((state_q == IF_BUSY) && end_xfer && !if_discard)
        if_rdata_q <= i_bus_ack ? i_bus_rdata : '0;

      // Stores never disturb the held load data.
      if ((state_q == MEM_BUSY) && end_xfer && !req_q.we)
        mem_rdata_q <= i_bus_ack ? i_bus_rdata : '0;

      if (state_q == IF_BUSY)
        discard_q <= end_xfer ? 1'b0 : (discard_q || i_flush);
      else
        discard_q <= 1'b0;
    end
  end

  assign o_bus_cyc     = cyc_q;
  assign o_bus_we      = req_q.we;
  assign o_bus_sel     = req_q.sel;
  assign o_bus_addr    = N_ADDR'(req_q.addr);
  assign o_bus_wdata   = N_DATA'(req_q.wdata);
  assign o_bus_timeout = timeout_q;
  assign o_if_rdata    = if_rdata_q;
  assign o_mem_rdata   = mem_rdata_q;

  assign o_mem_stallreq = i_mem_ce && (state_q != MEM_DONE);
  assign o_if_stallreq  = i_if_ce  && (state_q != IF_DONE);

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Self-checking bench for bus_arbiter_ctrl with a result scoreboard.
module tb_bus_arbiter_ctrl;
  import cpu_bus_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_ce;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_stallreq;
  logic        i_mem_ce;
  logic        i_mem_we;
  logic [3:0]  i_mem_sel;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_mem_stallreq;
  logic        i_flush;
  logic        o_bus_cyc;
  logic        o_bus_we;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ack;
  logic        o_bus_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mdl_if_rdata  = '0;
  logic [31:0] mdl_mem_rdata = '0;

  bus_arbiter_ctrl #(.N_ADDR(32), .N_DATA(32), .MAX_WAIT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_ce(i_if_ce), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata),
    .o_if_stallreq(o_if_stallreq),
    .i_mem_ce(i_mem_ce), .i_mem_we(i_mem_we), .i_mem_sel(i_mem_sel),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .o_mem_rdata(o_mem_rdata),
    .o_mem_stallreq(o_mem_stallreq), .i_flush(i_flush),
    .o_bus_cyc(o_bus_cyc), .o_bus_we(o_bus_we), .o_bus_sel(o_bus_sel),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_rdata(i_bus_rdata), .i_bus_ack(i_bus_ack), .o_bus_timeout(o_bus_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_bus_cyc, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata, o_bus_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_bus: cyc=%0b we=%0b sel=%h addr=%h wdata=%h to=%0b expected all 0",
               o_bus_cyc, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata, o_bus_timeout);
    end
    checks++;
    if ({o_if_rdata, o_mem_rdata, o_if_stallreq, o_mem_stallreq} !== '0) begin
      errors++;
      $display("FAIL reset_rdata: if=%h mem=%h ifst=%0b memst=%0b expected 0",
               o_if_rdata, o_mem_rdata, o_if_stallreq, o_mem_stallreq);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected IDLE", dut.state_q);
    end
    i_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_bus_cyc !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_cyc: got %0b expected 0 (cycle %0d)", o_bus_cyc, k);
      end
    end
  endtask

  task automatic test_fetch();
    int   cyc_cnt = 0;
    bit   done = 0;
    exp_t e;
    i_if_ce   = 1'b1;
    i_if_addr = 32'h100;
    exp_q.push_back('{1'b1, 32'h2408000A});
    #1;
    checks++;
    if (o_if_stallreq !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall_req: got %0b expected 1", o_if_stallreq);
    end
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (dut.state_q == IF_DONE) begin
        done = 1;
        i_bus_ack = 1'b0;
      end else if (o_bus_cyc) begin
        cyc_cnt++;
        checks++;
        if ({o_bus_we, o_bus_sel, o_bus_addr} !== {1'b0, 4'hF, 32'h100}) begin
          errors++;
          $display("FAIL fetch_bus: we=%0b sel=%h addr=%h expected 0/f/00000100",
                   o_bus_we, o_bus_sel, o_bus_addr);
        end
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h2408000A;
      end
    end
    i_bus_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fetch_done: IF_DONE not reached within budget");
    end
    #1;
    checks++;
    if (o_if_stallreq !== 1'b0) begin
      errors++;
      $display("FAIL fetch_stall_done: got %0b expected 0", o_if_stallreq);
    end
    checks++;
    if (cyc_cnt != 1) begin
      errors++;
      $display("FAIL fetch_cyc_len: got %0d expected 1", cyc_cnt);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL fetch_sb: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (!e.is_if || o_if_rdata !== e.data) begin
        errors++;
        $display("FAIL fetch_rdata: got %h expected %h", o_if_rdata, e.data);
      end
      mdl_if_rdata = e.data;
    end
    i_if_ce = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    exp_t e;
    i_mem_ce = 1'b1; i_mem_we = 1'b0; i_mem_sel = 4'hF; i_mem_addr = 32'h200;
    i_if_ce  = 1'b1; i_if_addr = 32'h104;
    exp_q.push_back('{1'b0, 32'h11112222});
    exp_q.push_back('{1'b1, 32'h33334444});
    #1;
    checks++;
    if ({o_mem_stallreq, o_if_stallreq} !== 2'b11) begin
      errors++;
      $display("FAIL cont_stall_idle: got %b expected 11", {o_mem_stallreq, o_if_stallreq});
    end
    tick();
    checks++;
    if ({o_bus_cyc, o_bus_we, o_bus_addr} !== {1'b1, 1'b0, 32'h200}) begin
      errors++;
      $display("FAIL cont_mem_first: cyc=%0b we=%0b addr=%h expected 1/0/00000200",
               o_bus_cyc, o_bus_we, o_bus_addr);
    end
    i_bus_ack = 1'b1; i_bus_rdata = 32'h11112222;
    tick();
    i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
    #1;
    checks++;
    if ({o_bus_cyc, o_mem_stallreq, o_if_stallreq} !== 3'b001) begin
      errors++;
      $display("FAIL cont_mem_done: cyc/memst/ifst=%b expected 001",
               {o_bus_cyc, o_mem_stallreq, o_if_stallreq});
    end
    checks++;
    e = exp_q.pop_front();
    if (e.is_if || o_mem_rdata !== e.data) begin
      errors++;
      $display("FAIL cont_mem_rdata: got %h expected %h", o_mem_rdata, e.data);
    end
    mdl_mem_rdata = e.data;
    i_mem_ce = 1'b0;
    tick();
    checks++;
    if ({o_bus_cyc, o_if_stallreq} !== 2'b01) begin
      errors++;
      $display("FAIL cont_gap: cyc/ifst=%b expected 01", {o_bus_cyc, o_if_stallreq});
    end
    tick();
    checks++;
    if ({o_bus_cyc, o_bus_addr} !== {1'b1, 32'h104}) begin
      errors++;
      $display("FAIL cont_if_grant: cyc=%0b addr=%h expected 1/00000104", o_bus_cyc, o_bus_addr);
    end
    i_bus_ack = 1'b1; i_bus_rdata = 32'h33334444;
    tick();
    i_bus_ack = 1'b0;
    #1;
    checks++;
    if (o_if_stallreq !== 1'b0) begin
      errors++;
      $display("FAIL cont_if_done_stall: got %0b expected 0", o_if_stallreq);
    end
    checks++;
    e = exp_q.pop_front();
    if (!e.is_if || o_if_rdata !== e.data) begin
      errors++;
      $display("FAIL cont_if_rdata: got %h expected %h", o_if_rdata, e.data);
    end
    mdl_if_rdata = e.data;
    i_if_ce = 1'b0;
    tick();
  endtask

  task automatic test_store();
    i_mem_ce = 1'b1; i_mem_we = 1'b1; i_mem_sel = 4'b0011;
    i_mem_addr = 32'h280; i_mem_wdata = 32'hDEADBEEF;
    tick();
    // Requester inputs change after grant; bus fields must not follow.
    i_mem_we = 1'b0; i_mem_sel = 4'hF; i_mem_addr = 32'hFFFFFFFC; i_mem_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_bus_cyc, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata} !==
          {1'b1, 1'b1, 4'b0011, 32'h280, 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL store_stable[%0d]: cyc=%0b we=%0b sel=%h addr=%h wdata=%h",
                 k, o_bus_cyc, o_bus_we, o_bus_sel, o_bus_addr, o_bus_wdata);
      end
      i_bus_ack   = (k == 2);
      i_bus_rdata = 32'hBAD0BAD0;
      tick();
    end
    i_bus_ack = 1'b0;
    checks++;
    if ({o_bus_cyc, dut.state_q} !== {1'b0, MEM_DONE}) begin
      errors++;
      $display("FAIL store_done: cyc=%0b state=%0d expected 0/MEM_DONE", o_bus_cyc, dut.state_q);
    end
    checks++;
    if (o_mem_rdata !== mdl_mem_rdata) begin
      errors++;
      $display("FAIL store_rdata_kept: got %h expected %h", o_mem_rdata, mdl_mem_rdata);
    end
    i_mem_ce = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int if_done_seen = 0;
    i_if_ce = 1'b1; i_if_addr = 32'h400;
    tick();
    i_flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (dut.state_q == IF_DONE) if_done_seen++;
      checks++;
      if (o_bus_cyc !== 1'b1) begin
        errors++;
        $display("FAIL flush_cyc_held[%0d]: got %0b expected 1", k, o_bus_cyc);
      end
      i_bus_ack   = (k == 2);
      i_bus_rdata = 32'hCAFEF00D;
      tick();
      i_flush = 1'b0;
    end
    i_bus_ack = 1'b0;
    if (dut.state_q == IF_DONE) if_done_seen++;
    #1;
    checks++;
    if ({o_bus_cyc, o_if_stallreq} !== 2'b01) begin
      errors++;
      $display("FAIL flush_after: cyc/ifst=%b expected 01", {o_bus_cyc, o_if_stallreq});
    end
    checks++;
    if (o_if_rdata !== mdl_if_rdata) begin
      errors++;
      $display("FAIL flush_rdata_kept: got %h expected %h", o_if_rdata, mdl_if_rdata);
    end
    checks++;
    if (if_done_seen != 0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL flush_skip_done: if_done cycles=%0d state=%0d expected 0/IDLE",
               if_done_seen, dut.state_q);
    end
    i_if_ce = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int   cyc_cnt = 0;
    int   to_cnt = 0;
    bit   done = 0;
    exp_t e;
    i_mem_ce = 1'b1; i_mem_we = 1'b0; i_mem_sel = 4'hF; i_mem_addr = 32'h500;
    i_bus_rdata = 32'hFFFFFFFF;
    exp_q.push_back('{1'b0, 32'h0});
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (o_bus_cyc) cyc_cnt++;
      if (o_bus_timeout) to_cnt++;
      if (dut.state_q == MEM_DONE) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout_done: MEM_DONE not reached within budget");
    end
    checks++;
    e = exp_q.pop_front();
    if (o_mem_rdata !== e.data) begin
      errors++;
      $display("FAIL timeout_rdata: got %h expected %h", o_mem_rdata, e.data);
    end
    mdl_mem_rdata = e.data;
    i_mem_ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_bus_timeout) to_cnt++;
    end
    checks++;
    if (cyc_cnt != 16) begin
      errors++;
      $display("FAIL timeout_cyc_len: got %0d expected 16", cyc_cnt);
    end
    checks++;
    if (to_cnt != 1) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d pulses expected 1", to_cnt);
    end
  endtask

  task automatic test_ack_at_limit();
    int   busy_n = 0;
    int   to_cnt = 0;
    bit   done = 0;
    exp_t e;
    i_mem_ce = 1'b1; i_mem_we = 1'b0; i_mem_sel = 4'hF; i_mem_addr = 32'h600;
    exp_q.push_back('{1'b0, 32'h0BADCAFE});
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (o_bus_timeout) to_cnt++;
      if (dut.state_q == MEM_DONE) begin
        done = 1;
        i_bus_ack = 1'b0;
      end else if (o_bus_cyc) begin
        busy_n++;
        i_bus_ack   = (busy_n == 16);
        i_bus_rdata = 32'h0BADCAFE;
      end
    end
    i_bus_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL limit_done: MEM_DONE not reached within budget");
    end
    checks++;
    e = exp_q.pop_front();
    if (o_mem_rdata !== e.data) begin
      errors++;
      $display("FAIL limit_rdata: got %h expected %h", o_mem_rdata, e.data);
    end
    mdl_mem_rdata = e.data;
    i_mem_ce = 1'b0;
    tick();
    if (o_bus_timeout) to_cnt++;
    checks++;
    if (to_cnt != 0) begin
      errors++;
      $display("FAIL limit_no_pulse: got %0d pulses expected 0", to_cnt);
    end
  endtask

  task automatic test_reset_mid();
    i_mem_ce = 1'b1; i_mem_we = 1'b0; i_mem_sel = 4'hF; i_mem_addr = 32'h700;
    tick();
    tick();
    checks++;
    if (o_bus_cyc !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: cyc=%0b expected 1", o_bus_cyc);
    end
    i_rst = 1'b1;
    tick();
    checks++;
    if ({o_bus_cyc, o_bus_addr, o_bus_timeout} !== '0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL rstmid_bus: cyc=%0b addr=%h state=%0d expected 0/0/IDLE",
               o_bus_cyc, o_bus_addr, dut.state_q);
    end
    checks++;
    if ({o_if_rdata, o_mem_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL rstmid_rdata: if=%h mem=%h expected 0", o_if_rdata, o_mem_rdata);
    end
    i_rst = 1'b0;
    i_mem_ce = 1'b0;
    tick();
    checks++;
    if (o_bus_cyc !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: cyc=%0b expected 0", o_bus_cyc);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_if_ce = 1'b0; i_if_addr = '0;
    i_mem_ce = 1'b0; i_mem_we = 1'b0; i_mem_sel = '0; i_mem_addr = '0; i_mem_wdata = '0;
    i_flush = 1'b0; i_bus_rdata = '0; i_bus_ack = 1'b0;
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_flush();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
